// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: load-use stalls, branch/jump flushes,
// MUL/DIV freezes and SYSCALL halt/resume, plus saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memtoreg,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_wbreg,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  input  logic             ex_is_div,
  input  logic             wb_halt,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             bb_data,
  output logic             bb_bj,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MD_BUSY, HALT} state_e;

  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [5:0]       md_cnt_q, md_cnt_d;
  logic             halt_mask_q, halt_mask_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [4:0]       en;
  logic             lu, halt_req, run_seq, md_ok;

  assign lu = ex_memtoreg & ex_regwrite & (ex_wbreg != 5'd0) &
              ((id_uses_rs & (id_rs == ex_wbreg)) | (id_uses_rt & (id_rt == ex_wbreg)));
  assign halt_req = wb_halt & ~halt_mask_q;
  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;

  always_comb begin
    en          = 5'b11111;
    ifid_clr    = 1'b0;
    bb_data     = 1'b0;
    bb_bj       = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    halt_mask_d = halt_mask_q;
    run_seq     = 1'b0;
    md_ok       = 1'b0;
    case (state_q)
      RUN: begin
        // The mask only has to survive the first RUN cycle after a resume.
        halt_mask_d = 1'b0;
        if (halt_req) begin
          en      = 5'b00000;
          state_d = HALT;
        end else begin
          run_seq = 1'b1;
          md_ok   = 1'b1;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q != 6'd0) begin
          en       = 5'b00000;
          busy     = 1'b1;
          md_cnt_d = md_cnt_q - 6'd1;
        end else begin
          run_seq = 1'b1;
          state_d = RUN;
        end
      end
      HALT: begin
        en     = 5'b00000;
        halted = 1'b1;
        if (resume) begin
          state_d     = RUN;
          halt_mask_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Release cycle of a freeze reuses this chain with md_ok=0 so the held op advances.
    if (run_seq) begin
      if (ex_branch_taken) begin
        ifid_clr = 1'b1;
        bb_bj    = 1'b1;
        en[2]    = 1'b0;
      end else if (md_ok && ex_muldiv_start) begin
        en       = 5'b00000;
        md_cnt_d = ex_is_div ? DIV_LD : MUL_LD;
        state_d  = MD_BUSY;
      end else if (lu) begin
        en      = 5'b00011;
        bb_data = 1'b1;
      end else if (id_jump) begin
        ifid_clr = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_en && state_q != HALT && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if ((ifid_clr || bb_bj) && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      md_cnt_q    <= 6'd0;
      halt_mask_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      halt_mask_q <= halt_mask_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
